window_streamer: RTL

- Consumer end of the row-padding interface: accepts one 3-row padded snapshot for R, G and B (three rows each) and streams it out as 3x3x3 convolution windows, one column position per handshake, stride 1.
- Sits between the padding row registers and the first convolution engine.
- Stores the snapshot in shift registers and shifts one pixel per accepted window, so the window is always the lowest three pixels.

---
 rtl/window_streamer_if.sv | 42 ++++
 rtl/window_streamer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/window_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : window_streamer_if
//  Description : Snapshot-in / window-out bus of the window streamer. The
//                padding side offers nine padded rows with a valid/ready
//                handshake. The convolution side receives 3x3x3 windows with a
//                valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface window_streamer_if #(
    parameter int W     = 418,
    parameter int PIX_W = 8,
    parameter int CNT_W = 9
);
    // snapshot side
    logic                 rows_valid;
    logic                 rows_ready;
    logic [W*PIX_W-1:0]   R_row0, R_row1, R_row2;
    logic [W*PIX_W-1:0]   G_row0, G_row1, G_row2;
    logic [W*PIX_W-1:0]   B_row0, B_row1, B_row2;
    // window side
    logic                 win_valid;
    logic                 win_ready;
    logic [27*PIX_W-1:0]  win_data;
    logic [CNT_W-1:0]     win_col;
    logic                 win_last;

    // master: the environment, which supplies snapshots and consumes windows
    modport master (
        output rows_valid, R_row0, R_row1, R_row2, G_row0, G_row1, G_row2,
               B_row0, B_row1, B_row2, win_ready,
        input  rows_ready, win_valid, win_data, win_col, win_last
    );

    // slave: the streamer itself
    modport slave (
        input  rows_valid, R_row0, R_row1, R_row2, G_row0, G_row1, G_row2,
               B_row0, B_row1, B_row2, win_ready,
        output rows_ready, win_valid, win_data, win_col, win_last
    );
endinterface
`default_nettype wire

// File: rtl/window_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : window_streamer
//  Description : Captures one padded 3-row RGB snapshot into nine shift
//                registers and streams it out as stride-1 3x3x3 windows. Each
//                accepted window shifts every register right by one pixel, so
//                the current window is always the lowest three pixels.
//  Revision    : 1.0  initial release
// ============================================================================
module window_streamer #(
    parameter int W     = 418,
    parameter int PIX_W = 8,
    parameter int CNT_W = 9
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            clear,
    output logic                 busy,
    window_streamer_if.slave     bus
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(W - 3);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t               state_q;
    logic                 rows_ready_q;
    logic                 win_valid_q;
    logic                 win_last_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     win_col_q;
    // index = ch*3 + row : 0..2 red, 3..5 green, 6..8 blue
    logic [W*PIX_W-1:0]   sr_q [9];
    logic [27*PIX_W-1:0]  w_win_data;

    // Control FSM and snapshot shift registers; all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rows_ready_q <= 1'b1;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            win_col_q    <= '0;
            for (int i = 0; i < 9; i++) sr_q[i] <= '0;
        end else if (clear) begin
            // clear outranks both a pending load and a pending accept
            state_q      <= S_IDLE;
            rows_ready_q <= 1'b1;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            win_col_q    <= '0;
            for (int i = 0; i < 9; i++) sr_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rows_valid && rows_ready_q) begin
                        sr_q[0]      <= bus.R_row0;
                        sr_q[1]      <= bus.R_row1;
                        sr_q[2]      <= bus.R_row2;
                        sr_q[3]      <= bus.G_row0;
                        sr_q[4]      <= bus.G_row1;
                        sr_q[5]      <= bus.G_row2;
                        sr_q[6]      <= bus.B_row0;
                        sr_q[7]      <= bus.B_row1;
                        sr_q[8]      <= bus.B_row2;
                        state_q      <= S_STREAM;
                        rows_ready_q <= 1'b0;
                        win_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        win_col_q    <= '0;
                        // a 3-pixel row yields a single, final window
                        win_last_q   <= (LAST_COL == '0);
                    end
                end
                S_STREAM: begin
                    if (bus.win_ready) begin
                        for (int i = 0; i < 9; i++) sr_q[i] <= sr_q[i] >> PIX_W;
                        if (win_col_q == LAST_COL) begin
                            state_q      <= S_IDLE;
                            rows_ready_q <= 1'b1;
                            win_valid_q  <= 1'b0;
                            busy_q       <= 1'b0;
                            win_last_q   <= 1'b0;
                            win_col_q    <= '0;
                        end else begin
                            win_col_q    <= win_col_q + 1'b1;
                            win_last_q   <= ((win_col_q + 1'b1) == LAST_COL);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Window is the low three pixels of each register, forced to zero when idle.
    always_comb begin
        w_win_data = '0;
        if (win_valid_q) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int r = 0; r < 3; r++) begin
                    for (int k = 0; k < 3; k++) begin
                        w_win_data[((ch*9)+r*3+k)*PIX_W +: PIX_W] = sr_q[ch*3+r][k*PIX_W +: PIX_W];
                    end
                end
            end
        end
    end

    assign bus.rows_ready = rows_ready_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_data   = w_win_data;
    assign bus.win_col    = win_col_q;
    assign bus.win_last   = win_last_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire
